// File: rtl/rx_frame_ring.sv
// rx_frame_ring: ring of SLOTS fixed-size frame buffers with per-slot lengths.
// Runt, oversize, errored and no-room frames are dropped and counted.
module rx_frame_ring #(
  parameter int SLOTS      = 4,
  parameter int SLOT_DEPTH = 2048,
  parameter int MIN_LEN    = 14,
  parameter int CNT_W      = 16
) (
  input  logic                          RX_CLK,
  input  logic                          rst,
  input  logic                          in_data_v,
  input  logic [7:0]                    in_data,
  input  logic                          in_err,
  input  logic                          irq_en,
  input  logic [$clog2(SLOT_DEPTH)-1:0] rd_addr,
  output logic [7:0]                    rd_data,
  input  logic                          rd_release,
  output logic                          frame_avail,
  output logic [$clog2(SLOT_DEPTH):0]   head_len,
  output logic [$clog2(SLOTS):0]        frame_count,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          rx_irq
);
  localparam int AW = $clog2(SLOT_DEPTH);
  localparam int PW = $clog2(SLOTS);
  localparam logic [AW:0] MIN_L = MIN_LEN[AW:0];
  localparam logic [PW:0] FULL  = SLOTS[PW:0];
  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;
  state_t            r_state;
  logic [7:0]        r_mem [SLOTS*SLOT_DEPTH];
  logic [AW:0]       r_len [SLOTS];
  logic [PW-1:0]     r_head, r_tail;
  logic [PW:0]       r_count;
  logic [AW:0]       r_wr_off;
  logic              r_err;
  logic [CNT_W-1:0]  r_drop;
  logic              r_irq;
  logic [7:0]        r_rd_data;
  logic              w_full, w_we, w_commit, w_drop, w_rel, w_avail;
  logic [AW-1:0]     w_woff;
  assign w_full   = r_count == FULL;
  assign w_avail  = r_count != '0;
  assign w_rel    = rd_release & w_avail;
  assign w_woff   = r_state == IDLE ? '0 : r_wr_off[AW-1:0];
  // Full-ring frames are routed to DISCARD at the first byte, so the tail never hits the head.
  assign w_we     = !rst & in_data_v & ((r_state == IDLE & !w_full) | (r_state == RECV & !r_wr_off[AW]));
  assign w_commit = r_state == RECV & !in_data_v & !r_err & r_wr_off >= MIN_L;
  assign w_drop   = !in_data_v & ((r_state == RECV & (r_err | r_wr_off < MIN_L)) | r_state == DISCARD);
  always_ff @(posedge RX_CLK)
    if (w_we) r_mem[{r_tail, w_woff}] <= in_data;
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      r_state   <= IDLE;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wr_off  <= '0;
      r_err     <= 1'b0;
      r_drop    <= '0;
      r_irq     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[{r_head, rd_addr}];
      r_irq     <= w_avail & irq_en;
      r_count   <= r_count + (PW+1)'(w_commit) - (PW+1)'(w_rel);
      if (w_rel) r_head <= r_head + 1'b1;
      if (w_commit) begin
        r_len[r_tail] <= r_wr_off;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
      case (r_state)
        IDLE:
          if (in_data_v) begin
            if (w_full) r_state <= DISCARD;
            else begin
              r_wr_off <= (AW+1)'(1);
              r_err    <= in_err;
              r_state  <= RECV;
            end
          end
        RECV:
          if (!in_data_v) r_state <= IDLE;
          else if (r_wr_off[AW]) r_state <= DISCARD;
          else begin
            r_wr_off <= r_wr_off + 1'b1;
            r_err    <= r_err | in_err;
          end
        DISCARD: if (!in_data_v) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign rd_data     = r_rd_data;
  assign frame_avail = w_avail;
  assign head_len    = w_avail ? r_len[r_head] : '0;
  assign frame_count = r_count;
  assign drop_cnt    = r_drop;
  assign rx_irq      = r_irq;
endmodule

// File: tb/tb_rx_frame_ring.sv
// tb_rx_frame_ring: directed checks of rx_frame_ring with hand-computed expectations.
module tb_rx_frame_ring;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_data_v = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_err = 1'b0;
  logic        irq_en = 1'b0;
  logic [10:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_release = 1'b0;
  logic        frame_avail;
  logic [11:0] head_len;
  logic [2:0]  frame_count;
  logic [15:0] drop_cnt;
  logic        rx_irq;
  int n_chk = 0;
  int n_pass = 0;
  rx_frame_ring dut (
    .RX_CLK(clk), .rst(rst), .in_data_v(in_data_v), .in_data(in_data), .in_err(in_err),
    .irq_en(irq_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_release(rd_release),
    .frame_avail(frame_avail), .head_len(head_len), .frame_count(frame_count),
    .drop_cnt(drop_cnt), .rx_irq(rx_irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic send(input int n, input logic [7:0] seed, input int err_at, input logic rel);
    for (int i = 0; i < n; i++) begin
      in_data_v = 1'b1;
      in_data   = seed + 8'(i);
      in_err    = (i == err_at);
      @(negedge clk);
    end
    in_data_v  = 1'b0;
    in_err     = 1'b0;
    rd_release = rel;
    @(negedge clk);
    rd_release = 1'b0;
  endtask
  task automatic release_head();
    rd_release = 1'b1;
    @(negedge clk);
    rd_release = 1'b0;
  endtask
  task automatic rd(input string tag, input int addr, input logic [7:0] exp);
    rd_addr = 11'(addr);
    @(negedge clk);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst_avail", 32'(frame_avail), 0);
    chk("rst_len", 32'(head_len), 0);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_irq", 32'(rx_irq), 0);
    chk("rst_rd", 32'(rd_data), 0);
    // single 64-byte frame
    send(64, 8'h00, -1, 1'b0);
    chk("one_avail", 32'(frame_avail), 1);
    chk("one_len", 32'(head_len), 64);
    chk("one_count", 32'(frame_count), 1);
    rd("one_rd5", 5, 8'h05);
    chk("one_irq_off", 32'(rx_irq), 0);
    irq_en = 1'b1;
    @(negedge clk);
    chk("one_irq_on", 32'(rx_irq), 1);
    irq_en = 1'b0;
    release_head();
    chk("one_rel_count", 32'(frame_count), 0);
    chk("one_rel_len", 32'(head_len), 0);
    // full ring from fresh pointers
    do_reset();
    for (int k = 0; k < 5; k++) send(60, 8'(k * 16), -1, 1'b0);
    chk("full_count", 32'(frame_count), 4);
    chk("full_drop", 32'(drop_cnt), 1);
    release_head();
    chk("full_rel_count", 32'(frame_count), 3);
    rd("full_head1", 0, 8'h10);
    send(60, 8'h60, -1, 1'b0);
    chk("wrap_count", 32'(frame_count), 4);
    chk("wrap_drop", 32'(drop_cnt), 1);
    release_head();
    release_head();
    release_head();
    chk("wrap_rel_count", 32'(frame_count), 1);
    chk("wrap_len", 32'(head_len), 60);
    rd("wrap_rd0", 0, 8'h60);
    rd("wrap_rd59", 59, 8'h9B);
    release_head();
    chk("wrap_empty", 32'(frame_count), 0);
    // length limits
    send(2049, 8'h00, -1, 1'b0);
    chk("over_drop", 32'(drop_cnt), 2);
    chk("over_count", 32'(frame_count), 0);
    send(2048, 8'h00, -1, 1'b0);
    chk("max_count", 32'(frame_count), 1);
    chk("max_len", 32'(head_len), 2048);
    rd("max_rd2047", 2047, 8'hFF);
    rd("max_rd1000", 1000, 8'hE8);
    release_head();
    send(13, 8'h00, -1, 1'b0);
    chk("runt_drop", 32'(drop_cnt), 3);
    chk("runt_count", 32'(frame_count), 0);
    send(14, 8'h00, -1, 1'b0);
    chk("min_count", 32'(frame_count), 1);
    chk("min_len", 32'(head_len), 14);
    chk("min_drop", 32'(drop_cnt), 3);
    release_head();
    // errored frame
    send(100, 8'h00, 50, 1'b0);
    chk("err_drop", 32'(drop_cnt), 4);
    chk("err_count", 32'(frame_count), 0);
    // commit and release together
    send(20, 8'hA0, -1, 1'b0);
    send(30, 8'hB0, -1, 1'b0);
    chk("sim_pre_count", 32'(frame_count), 2);
    send(40, 8'hC0, -1, 1'b1);
    chk("sim_count", 32'(frame_count), 2);
    chk("sim_len", 32'(head_len), 30);
    rd("sim_rd0", 0, 8'hB0);
    release_head();
    chk("sim_len2", 32'(head_len), 40);
    rd("sim_rd2", 0, 8'hC0);
    release_head();
    chk("sim_empty", 32'(frame_count), 0);
    // reset mid-frame
    irq_en = 1'b1;
    send(20, 8'h00, -1, 1'b0);
    @(negedge clk);
    chk("mid_pre_irq", 32'(rx_irq), 1);
    for (int i = 0; i < 40; i++) begin
      in_data_v = 1'b1;
      in_data   = 8'(i);
      rst       = (i == 30);
      @(negedge clk);
      if (i == 30) begin
        chk("mid_avail", 32'(frame_avail), 0);
        chk("mid_count", 32'(frame_count), 0);
        chk("mid_len", 32'(head_len), 0);
        chk("mid_drop", 32'(drop_cnt), 0);
        chk("mid_irq", 32'(rx_irq), 0);
        chk("mid_rd", 32'(rd_data), 0);
      end
    end
    rst = 1'b0;
    in_data_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_tail_drop", 32'(drop_cnt), 1);
    chk("mid_tail_count", 32'(frame_count), 0);
    chk("mid_tail_irq", 32'(rx_irq), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
